// File: rtl/instr_encoder_if.sv
// Bundles for the instr_encoder: field-beat input channel and memory write channel.
// The beat source is the master of instr_beat_if; the encoder is the master of mem_wr_if.
interface instr_beat_if #(
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       instr_type;
    logic [5:0]       opcode;
    logic [4:0]       register_one;
    logic [4:0]       register_two;
    logic [4:0]       destination_reg;
    logic [4:0]       shift;
    logic [5:0]       function_code;
    logic [31:0]      immediate;
    logic [25:0]      memory;
    logic             err;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, instr_type, opcode, register_one, register_two,
               destination_reg, shift, function_code, immediate, memory,
        input  in_ready, err, count
    );
    modport slave (
        input  in_valid, instr_type, opcode, register_one, register_two,
               destination_reg, shift, function_code, immediate, memory,
        output in_ready, err, count
    );
endinterface

interface mem_wr_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;

    modport master (
        output address, write, writedata, byteenable,
        input  waitrequest
    );
    modport slave (
        input  address, write, writedata, byteenable,
        output waitrequest
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS R/I/J field-beat encoder: legal beats are encoded into a FIFO and drained
// to instruction memory at consecutive word addresses by a write FSM.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000
) (
    input logic         clk,
    input logic         reset,
    instr_beat_if.slave beat,
    mem_wr_if.master    mem
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    function automatic logic [31:0] encode_word(
        input logic [1:0]  itype,
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [5:0]  fn,
        input logic [31:0] imm,
        input logic [25:0] tgt
    );
        case (itype)
            2'b00:   encode_word = {6'b000000, rs, rt, rd, sh, fn};
            2'b01:   encode_word = {op, rs, rd, imm[15:0]};
            2'b10:   encode_word = {op, tgt};
            default: encode_word = 32'h0;
        endcase
    endfunction

    // I-type immediates must fit in 16 signed bits; opcodes 0/2/3 belong to R and J.
    function automatic logic beat_legal(
        input logic [1:0]  itype,
        input logic [5:0]  op,
        input logic [31:0] imm
    );
        logic jump_op;
        jump_op = (op == 6'b000010) || (op == 6'b000011);
        case (itype)
            2'b00:   beat_legal = (op == 6'b000000);
            2'b01:   beat_legal = (op != 6'b000000) && !jump_op &&
                                  (imm[31:16] == {16{imm[15]}});
            2'b10:   beat_legal = jump_op;
            default: beat_legal = 1'b0;
        endcase
    endfunction

    state_t           state_q;
    logic             ready_en_q;
    logic             err_q;
    logic             write_q;
    logic [31:0]      writedata_q;
    logic [31:0]      address_q;
    logic [31:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             in_ready;
    logic             legal;
    logic             accept;
    logic             push;
    logic             pop;
    logic             have_next;
    logic [31:0]      enc_word;
    logic [31:0]      next_word;
    logic [PTR_W-1:0] rd_next;

    assign legal    = beat_legal(beat.instr_type, beat.opcode, beat.immediate);
    assign enc_word = encode_word(beat.instr_type, beat.opcode, beat.register_one,
                                  beat.register_two, beat.destination_reg, beat.shift,
                                  beat.function_code, beat.immediate, beat.memory);

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = ready_en_q && (count_q < CNT_W'(DEPTH));
    assign accept    = beat.in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = (state_q == WRITE) && !mem.waitrequest;
    assign rd_next   = rd_ptr_q + PTR_W'(1);
    assign have_next = (count_q > CNT_W'(1)) || push;
    // With only the in-flight word stored, the follow-on word is the one being pushed now.
    assign next_word = (count_q > CNT_W'(1)) ? fifo_q[rd_next] : enc_word;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            err_q       <= 1'b0;
            write_q     <= 1'b0;
            writedata_q <= 32'h0;
            address_q   <= BASE_ADDR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            ready_en_q <= 1'b1;
            err_q      <= accept && !legal;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            // The head word stays counted in the FIFO until memory accepts it.
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= WRITE;
                        write_q     <= 1'b1;
                        writedata_q <= fifo_q[rd_ptr_q];
                    end
                end
                WRITE: begin
                    if (!mem.waitrequest) begin
                        rd_ptr_q  <= rd_next;
                        address_q <= address_q + 32'd4;
                        if (have_next) begin
                            writedata_q <= next_word;
                        end else begin
                            state_q <= IDLE;
                            write_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat.in_ready  = in_ready;
    assign beat.err       = err_q;
    assign beat.count     = count_q;
    assign mem.address    = address_q;
    assign mem.write      = write_q;
    assign mem.writedata  = writedata_q;
    assign mem.byteenable = {4{write_q}};

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, backpressure and reset-mid-write
// sequences, then random beats against a behavioural encoder model and write scoreboard.
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_beat_if #(.CNT_W(3)) bi();
    mem_wr_if mi();

    instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .beat  (bi),
        .mem   (mi)
    );

    typedef struct {
        logic [1:0]  t;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] tgt;
        logic        legal;
        logic [31:0] word;
        logic [31:0] addr;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          err_exp = 0;
    int          err_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_addr = BASE;
    bit          rnd_done;
    vec_t        tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] t, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                input logic [5:0] fn, input logic [31:0] imm, input logic [25:0] tgt,
                                input logic legal, input logic [31:0] word, input logic [31:0] addr);
        vec_t v;
        v.t = t; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh; v.fn = fn;
        v.imm = imm; v.tgt = tgt; v.legal = legal; v.word = word; v.addr = addr;
        return v;
    endfunction

    // Reference model: legality and encoding from field weights, not bit concatenation.
    function automatic logic model_legal(input vec_t v);
        int simm;
        simm = $signed(v.imm);
        case (v.t)
            2'd0:    return v.op == 6'd0;
            2'd1:    return (v.op != 6'd0) && (v.op != 6'd2) && (v.op != 6'd3) &&
                            (simm >= -32768) && (simm <= 32767);
            2'd2:    return (v.op == 6'd2) || (v.op == 6'd3);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input vec_t v);
        case (v.t)
            2'd0:    return 32'(v.rs) * 32'd2097152 + 32'(v.rt) * 32'd65536 +
                            32'(v.rd) * 32'd2048 + 32'(v.sh) * 32'd64 + 32'(v.fn);
            2'd1:    return 32'(v.op) * 32'd67108864 + 32'(v.rs) * 32'd2097152 +
                            32'(v.rd) * 32'd65536 + (v.imm % 32'd65536);
            2'd2:    return 32'(v.op) * 32'd67108864 + 32'(v.tgt);
            default: return 32'd0;
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = mk(2'($urandom_range(0, 3)), 6'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), 6'($urandom), $urandom, 26'($urandom),
               1'b0, 32'd0, 32'd0);
        if ($urandom_range(0, 1) == 1) v.imm = {{16{v.imm[15]}}, v.imm[15:0]};
        if (v.t == 2'd0 && $urandom_range(0, 3) != 0) v.op = 6'd0;
        if (v.t == 2'd2 && $urandom_range(0, 3) != 0) v.op = 6'($urandom_range(2, 3));
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bi.instr_type      = v.t;
        bi.opcode          = v.op;
        bi.register_one    = v.rs;
        bi.register_two    = v.rt;
        bi.destination_reg = v.rd;
        bi.shift           = v.sh;
        bi.function_code   = v.fn;
        bi.immediate       = v.imm;
        bi.memory          = v.tgt;
    endtask

    task automatic send_beat(input vec_t v);
        bit accepted;
        accepted = 1'b0;
        apply(v);
        bi.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bi.in_ready) begin
                step();
                accepted = 1'b1;
                break;
            end
            step();
        end
        bi.in_valid = 1'b0;
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got not-accepted expected accepted");
        end else if (model_legal(v)) begin
            exp_q.push_back(model_word(v));
        end else begin
            err_exp++;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !mi.write) break;
            step();
        end
        check(name, 64'(exp_q.size()), 64'd0);
        check({name, "_idle"}, 64'(mi.write), 64'd0);
    endtask

    // Scoreboard: a write completes at the next edge when write=1 and waitrequest=0.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            mon_addr = BASE;
        end else begin
            if (mi.write && !mi.waitrequest) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_write: got data %h expected no write", mi.writedata);
                end else begin
                    check("wr_data", 64'(mi.writedata), 64'(exp_q.pop_front()));
                    check("wr_addr", 64'(mi.address), 64'(mon_addr));
                    check("wr_be", 64'(mi.byteenable), 64'hF);
                    mon_addr = mon_addr + 32'd4;
                end
            end
            if (bi.err) err_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vec_t bp[5];
        logic [31:0] addr0;

        tbl[0]  = mk(2'd0, 6'd0, 5'd21, 5'd14, 5'd20, 5'd10, 6'h30, 32'h0, 26'h0, 1'b1, 32'h02AEA2B0, 32'hBFC00000);
        tbl[1]  = mk(2'd1, 6'b010011, 5'd5, 5'd0, 5'd14, 5'd0, 6'h0, 32'hFFFFE080, 26'h0, 1'b1, 32'h4CAEE080, 32'hBFC00004);
        tbl[2]  = mk(2'd1, 6'b010011, 5'd5, 5'd0, 5'd14, 5'd0, 6'h0, 32'h00018000, 26'h0, 1'b0, 32'h0, 32'hBFC00008);
        tbl[3]  = mk(2'd2, 6'b000011, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h2BBE60C, 1'b1, 32'h0EBBE60C, 32'hBFC00008);
        tbl[4]  = mk(2'd2, 6'b000100, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h2BBE60C, 1'b0, 32'h0, 32'hBFC0000C);
        tbl[5]  = mk(2'd0, 6'b000001, 5'd21, 5'd14, 5'd20, 5'd10, 6'h30, 32'h0, 26'h0, 1'b0, 32'h0, 32'hBFC0000C);
        tbl[6]  = mk(2'd3, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h5, 32'h0, 26'h0, 1'b0, 32'h0, 32'hBFC0000C);
        tbl[7]  = mk(2'd1, 6'b000010, 5'd1, 5'd0, 5'd2, 5'd0, 6'h0, 32'h00000010, 26'h0, 1'b0, 32'h0, 32'hBFC0000C);
        tbl[8]  = mk(2'd1, 6'b001000, 5'd1, 5'd0, 5'd2, 5'd0, 6'h0, 32'h00007FFF, 26'h0, 1'b1, 32'h20227FFF, 32'hBFC0000C);
        tbl[9]  = mk(2'd2, 6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF, 32'hBFC00010);
        tbl[10] = mk(2'd1, 6'b001000, 5'd1, 5'd0, 5'd2, 5'd0, 6'h0, 32'hFFFF8000, 26'h0, 1'b1, 32'h20228000, 32'hBFC00014);
        tbl[11] = mk(2'd1, 6'b001000, 5'd1, 5'd0, 5'd2, 5'd0, 6'h0, 32'hFFFF7FFF, 26'h0, 1'b0, 32'h0, 32'hBFC00018);

        reset = 1'b1;
        bi.in_valid = 1'b0;
        mi.waitrequest = 1'b0;
        apply(mk(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 26'd0, 1'b0, 32'd0, 32'd0));
        step();
        step();
        check("rst_write", 64'(mi.write), 64'd0);
        check("rst_count", 64'(bi.count), 64'd0);
        check("rst_be", 64'(mi.byteenable), 64'd0);
        check("rst_wdata", 64'(mi.writedata), 64'd0);
        check("rst_err", 64'(bi.err), 64'd0);
        check("rst_ready", 64'(bi.in_ready), 64'd0);
        check("rst_addr", 64'(mi.address), 64'(BASE));
        reset = 1'b0;
        #1;
        check("ready_before_edge", 64'(bi.in_ready), 64'd0);
        step();
        check("ready_first_edge", 64'(bi.in_ready), 64'd1);

        foreach (tbl[i]) begin
            send_beat(tbl[i]);
            if (tbl[i].legal) begin
                check("lat_idle", 64'(mi.write), 64'd0);
                step();
                check("lat_write", 64'(mi.write), 64'd1);
                check("vec_word", 64'(mi.writedata), 64'(tbl[i].word));
                check("vec_addr", 64'(mi.address), 64'(tbl[i].addr));
                step();
                check("vec_done", 64'(mi.write), 64'd0);
            end else begin
                check("ill_err", 64'(bi.err), 64'd1);
                check("ill_nowrite", 64'(mi.write), 64'd0);
                step();
                check("ill_err_clear", 64'(bi.err), 64'd0);
                check("ill_nowrite2", 64'(mi.write), 64'd0);
                check("ill_addr", 64'(mi.address), 64'(tbl[i].addr));
                check("ill_count", 64'(bi.count), 64'd0);
            end
        end

        // Backpressure: fill the FIFO while memory stalls, then release.
        for (int k = 0; k < 5; k++) begin
            bp[k] = rand_vec();
            bp[k].t = 2'd0;
            bp[k].op = 6'd0;
        end
        mi.waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) send_beat(bp[k]);
        addr0 = mon_addr;
        check("bp_count", 64'(bi.count), 64'd4);
        check("bp_ready", 64'(bi.in_ready), 64'd0);
        check("bp_write", 64'(mi.write), 64'd1);
        fork
            send_beat(bp[4]);
            begin
                for (int k = 0; k < 6; k++) begin
                    step();
                    check("bp_hold_ready", 64'(bi.in_ready), 64'd0);
                    check("bp_hold_write", 64'(mi.write), 64'd1);
                    check("bp_hold_data", 64'(mi.writedata), 64'(model_word(bp[0])));
                    check("bp_hold_addr", 64'(mi.address), 64'(addr0));
                end
                mi.waitrequest = 1'b0;
            end
        join
        drain("bp_drain");
        check("bp_final_addr", 64'(mi.address), 64'(addr0 + 32'd20));

        // Reset while a write is stalled.
        mi.waitrequest = 1'b1;
        v = bp[0];
        send_beat(v);
        send_beat(v);
        check("pre_rst_write", 64'(mi.write), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_write", 64'(mi.write), 64'd0);
        check("mid_rst_count", 64'(bi.count), 64'd0);
        check("mid_rst_addr", 64'(mi.address), 64'(BASE));
        check("mid_rst_be", 64'(mi.byteenable), 64'd0);
        check("mid_rst_wdata", 64'(mi.writedata), 64'd0);
        check("mid_rst_ready", 64'(bi.in_ready), 64'd0);
        step();
        step();
        mi.waitrequest = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_ready0", 64'(bi.in_ready), 64'd0);
        step();
        check("post_rst_ready1", 64'(bi.in_ready), 64'd1);
        check("post_rst_write", 64'(mi.write), 64'd0);

        // Random beats with random memory stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    send_beat(rand_vec());
                    if ($urandom_range(0, 3) == 0) step();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    mi.waitrequest = ($urandom_range(0, 2) == 0);
                    step();
                end
            end
        join
        mi.waitrequest = 1'b0;
        drain("rnd_drain");
        step();
        check("err_pulses", 64'(err_seen), 64'(err_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4: number of entries in the encoded-word FIFO (power of two, at least 2).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'hBFC00000: write address after reset.
Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a field beat is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: a beat is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-007 The block SHALL have port instr_type, input, 2 bits: 00 = R, 01 = I, 10 = J, 11 = illegal.
REQ-008 The block SHALL have the following field ports, all inputs: opcode (6 bits), register_one (5 bits, rs), register_two (5 bits, rt for R), destination_reg (5 bits, rd for R, rt for I), shift (5 bits), function_code (6 bits), immediate (32 bits, sign-extended value), memory (26 bits, jump target).
REQ-009 The block SHALL have port address, output, 32 bits: instruction-memory byte address.
REQ-010 The block SHALL have port write, output, 1 bit: write request.
REQ-011 The block SHALL have port writedata, output, 32 bits: encoded instruction.
REQ-012 The block SHALL have port byteenable, output, 4 bits: equal to 4'b1111 whenever write=1, 4'b0000 otherwise.
REQ-013 The block SHALL have port waitrequest, input, 1 bit: memory stall.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected beat.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 The R-type encoding SHALL be {6'b000000, register_one, register_two, destination_reg, shift, function_code}, and the beat SHALL be legal only if opcode=000000.
REQ-017 The I-type encoding SHALL be {opcode, register_one, destination_reg, immediate[15:0]}, and the beat SHALL be legal only if opcode is none of 000000, 000010, 000011, and immediate[31:16] all equal immediate[15].
REQ-018 The J-type encoding SHALL be {opcode, memory}, and the beat SHALL be legal only if opcode is 000010 or 000011.
REQ-019 A beat with instr_type=11 SHALL be illegal.
REQ-020 in_ready SHALL equal (count < DEPTH), using the registered count; a pop in the same cycle SHALL NOT raise in_ready combinationally.
REQ-021 An accepted legal beat SHALL be pushed into the FIFO on that edge.
REQ-022 An accepted illegal beat SHALL be consumed, not pushed, and SHALL set err=1 for exactly the following cycle.
REQ-023 Write FSM state IDLE: write=0; on the next edge with FIFO non-empty, the FSM SHALL go to WRITE, load writedata from the FIFO head, and set write=1.
REQ-024 Write FSM state WRITE: address, writedata and write SHALL hold stable while waitrequest=1.
REQ-025 In WRITE, on an edge with waitrequest=0, the FSM SHALL pop the FIFO and set address to address+4, wrapping modulo 2^32.
REQ-026 After that pop, if the FIFO still holds a word (including one pushed on the same edge), the FSM SHALL stay in WRITE with the next word (back-to-back, no idle cycle); otherwise it SHALL return to IDLE.
REQ-027 A simultaneous push and pop SHALL leave count unchanged.
REQ-028 Latency: a legal beat accepted at edge N into an empty, idle block SHALL produce write=1 after edge N+1.
REQ-029 Words SHALL be written in acceptance order, and none SHALL be dropped or duplicated.

Reset
REQ-030 While reset=1, and immediately on its assertion, the block SHALL drive: state IDLE, count=0, write=0, byteenable=0, writedata=0, err=0, in_ready=0, address=BASE_ADDR.
REQ-031 Reset asserted mid-WRITE SHALL abandon the write: write drops asynchronously and FIFO contents are discarded.
REQ-032 After reset deasserts, in_ready SHALL rise on the first clock edge.

Verification
REQ-033 The bench SHALL cover: R beat with rs=21, rt=14, rd=20, shift=10, function_code=6'h30 -> writedata=32'h02AEA2B0 at address 32'hBFC00000.
REQ-034 The bench SHALL cover: I beat with opcode=010011, rs=5, destination_reg=14, immediate=32'hFFFFE080 -> writedata=32'h4CAEE080 at the next address, 32'hBFC00004.
REQ-035 The bench SHALL cover: I beat with immediate=32'h00018000 -> err=1 for one cycle, no write, address unchanged.
REQ-036 The bench SHALL cover: J beat with opcode=000011, memory=26'h2BBE60C -> writedata=32'h0EBBE60C; the same beat with opcode=000100 -> err pulse, no write.
REQ-037 The bench SHALL cover: waitrequest held high while 5 legal beats are offered -> in_ready=0 once count=4, outputs stable; after release, 5 writes in order at consecutive addresses.
REQ-038 The bench SHALL cover: reset asserted while write=1 and waitrequest=1 -> write=0 and count=0 immediately, address=32'hBFC00000.
